mem_stage: RTL and testbench

- Memory-access stage of the pipeline; sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives a request/response data-memory port and aligns store data and byte enables.
- Extracts, sign- or zero-extends load data, and builds the memwb_t bundle.
- Raises a stall to the hazard unit while a memory transaction is outstanding.

---
 rtl/pipeline_pkg.sv | 37 +++
 rtl/dmem_if.sv | 24 ++
 rtl/lsu_align.sv | 57 +++++
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the memory stage: EX/MEM and MEM/WB bundles,
// the memory-stage FSM encoding and the load/store funct3 codes.
package pipeline_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} mem_state_t;

   typedef struct packed {
      logic            mem_read;
      logic            mem_write;
      logic [2:0]      funct3;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] store_data;
      logic [4:0]      rd;
      logic            reg_write;
      logic [1:0]      result_src;
      logic [XLEN-1:0] pc_plus4;
   } exmem_t;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] load_data;
      logic [4:0]      rd;
      logic            reg_write;
      logic [1:0]      result_src;
      logic [XLEN-1:0] pc_plus4;
      logic            fault;
   } memwb_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response data-memory port; the memory stage is the master.
interface dmem_if;
   import pipeline_pkg::*;

   logic            dmem_req;
   logic            dmem_ready;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ready, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ready, dmem_rvalid, dmem_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: store byte enables and replicated write data,
// load extraction with sign/zero extension, and access legality.
module lsu_align
   import pipeline_pkg::*;
   (
      input  logic [2:0]      funct3,
      input  logic [1:0]      addr,
      input  logic            is_store,
      input  logic [XLEN-1:0] store_data,
      input  logic [XLEN-1:0] rdata,
      output logic [3:0]      be,
      output logic [XLEN-1:0] wdata,
      output logic [XLEN-1:0] load_data,
      output logic            misaligned,
      output logic            illegal
   );

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted    = rdata >> {addr, 3'b000};
      be         = 4'b1111;
      wdata      = store_data;
      load_data  = shifted;
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (funct3)
         F3_B: begin
            be        = 4'b0001 << addr;
            wdata     = {4{store_data[7:0]}};
            load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         end
         F3_H: begin
            be         = 4'b0011 << {addr[1], 1'b0};
            wdata      = {2{store_data[15:0]}};
            load_data  = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            misaligned = addr[0];
         end
         F3_W: begin
            misaligned = (addr != 2'b00);
         end
         F3_BU: begin
            load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            illegal   = is_store;
         end
         F3_HU: begin
            load_data  = {{(XLEN-16){1'b0}}, shifted[15:0]};
            misaligned = addr[0];
            illegal    = is_store;
         end
         default: illegal = 1'b1;
      endcase
      // Reads always fetch the whole word; extraction happens on the way back.
      if (!is_store) be = 4'b1111;
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage between EX/MEM and MEM/WB: runs one data-memory
// transaction per load/store and stalls upstream until its response returns.
// Define DMEM_TIMEOUT_EN to abort with a bus-error fault after TIMEOUT_CYCLES.
module mem_stage
   import pipeline_pkg::*;
   #(parameter int unsigned TIMEOUT_CYCLES = 64)
   (
      input  logic   clk,
      input  logic   reset,
      input  logic   in_valid,
      input  exmem_t inputs,
      output memwb_t outputs,
      output logic   out_valid,
      output logic   stall,
      output logic   fault,
      dmem_if.master dmem
   );

   mem_state_t      state_q, state_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            done_fault_q, done_fault_d;

   logic            is_mem, bad_op, legal_mem, timeout;
   logic            req_c, stall_c, valid_c, fault_c;
   logic [3:0]      be;
   logic [XLEN-1:0] wdata, load_data;
   logic            misaligned, illegal;

   lsu_align u_lsu_align (
      .funct3     (inputs.funct3),
      .addr       (inputs.alu_result[1:0]),
      .is_store   (inputs.mem_write),
      .store_data (inputs.store_data),
      .rdata      (rdata_q),
      .be         (be),
      .wdata      (wdata),
      .load_data  (load_data),
      .misaligned (misaligned),
      .illegal    (illegal)
   );

   assign is_mem    = in_valid & (inputs.mem_read | inputs.mem_write);
   assign bad_op    = misaligned | illegal | (inputs.mem_read & inputs.mem_write);
   assign legal_mem = is_mem & ~bad_op;

`ifdef DMEM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Timeout fires on the cycle whose increment would reach TIMEOUT_CYCLES-1.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = '0;
      else if (state_q == REQ || state_q == RSP)
         cnt_d = cnt_q + 1'b1;
   end

   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      rdata_d      = rdata_q;
      done_fault_d = done_fault_q;
      req_c        = 1'b0;
      stall_c      = 1'b0;
      valid_c      = 1'b0;
      fault_c      = 1'b0;
      unique case (state_q)
         IDLE: begin
            done_fault_d = 1'b0;
            if (legal_mem) begin
               req_c   = 1'b1;
               stall_c = 1'b1;
               state_d = dmem.dmem_ready ? RSP : REQ;
            end else if (in_valid) begin
               // Non-memory ops pass straight through; bad accesses fault here.
               valid_c = 1'b1;
               fault_c = is_mem;
            end
         end
         REQ: begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            if (dmem.dmem_ready) begin
               state_d = RSP;
            end else if (timeout) begin
               state_d      = DONE;
               done_fault_d = 1'b1;
            end
         end
         RSP: begin
            stall_c = 1'b1;
            if (dmem.dmem_rvalid) begin
               if (inputs.mem_read) rdata_d = dmem.dmem_rdata;
               state_d = DONE;
            end else if (timeout) begin
               state_d      = DONE;
               done_fault_d = 1'b1;
            end
         end
         DONE: begin
            valid_c = 1'b1;
            fault_c = done_fault_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         rdata_q      <= '0;
         done_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rdata_q      <= rdata_d;
         done_fault_q <= done_fault_d;
      end
   end

   // Control outputs are held low for the whole time reset is asserted.
   assign dmem.dmem_req   = req_c & reset;
   assign stall           = stall_c & reset;
   assign out_valid       = valid_c & reset;
   assign fault           = fault_c & reset;
   assign dmem.dmem_we    = inputs.mem_write;
   assign dmem.dmem_addr  = {inputs.alu_result[XLEN-1:2], 2'b00};
   assign dmem.dmem_be    = be;
   assign dmem.dmem_wdata = wdata;

   always_comb begin
      outputs            = '0;
      outputs.result     = inputs.alu_result;
      outputs.load_data  = load_data;
      outputs.rd         = inputs.rd;
      outputs.reg_write  = inputs.reg_write & ~fault_c;
      outputs.result_src = inputs.result_src;
      outputs.pc_plus4   = inputs.pc_plus4;
      outputs.fault      = fault_c;
   end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: a byte-level memory model predicts
// every MEM/WB bundle and memory request; a monitor checks them as they appear.
module tb_mem_stage;
   import pipeline_pkg::*;

   logic   clk = 1'b0;
   logic   reset = 1'b0;
   logic   in_valid = 1'b0;
   exmem_t inputs = '0;
   memwb_t outputs;
   logic   out_valid, stall, fault;

   dmem_if dmem_bus();

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYCLES(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .inputs    (inputs),
      .outputs   (outputs),
      .out_valid (out_valid),
      .stall     (stall),
      .fault     (fault),
      .dmem      (dmem_bus)
   );

   typedef struct {
      memwb_t m;
      bit     chk_load;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          is_store;
   } req_t;

   int         n_checks = 0;
   int         n_fail = 0;
   exp_t       exp_q[$];
   req_t       req_q[$];
   logic [7:0] byte_mem [int unsigned];
   bit         manual = 1'b1;
   int         force_d1 = -1;
   int         force_d2 = -1;
   int         last_d1 = 0;
   int         last_d2 = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] get_byte(input int unsigned a);
      if (!byte_mem.exists(a)) byte_mem[a] = 8'($urandom);
      return byte_mem[a];
   endfunction

   // Reference model: access size, alignment and extension from the ISA rules.
   task automatic model(input exmem_t op, output bit legal, output memwb_t e,
                        output req_t r, output bit is_load);
      int          size;
      int unsigned a;
      bit          is_mem;
      longint      v;
      a      = op.alu_result;
      is_mem = op.mem_read || op.mem_write;
      case (op.funct3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      legal = is_mem && size != 0 && !(op.mem_read && op.mem_write)
              && !(op.mem_write && op.funct3[2]) && (a % size) == 0;
      is_load      = legal && op.mem_read;
      e            = '0;
      e.result     = op.alu_result;
      e.rd         = op.rd;
      e.result_src = op.result_src;
      e.pc_plus4   = op.pc_plus4;
      e.fault      = is_mem && !legal;
      e.reg_write  = op.reg_write && !e.fault;
      r.we         = op.mem_write;
      r.addr       = op.alu_result & 32'hFFFF_FFFC;
      r.is_store   = op.mem_write;
      r.be         = 4'hF;
      r.wdata      = '0;
      if (is_load) begin
         v = 0;
         for (int i = 0; i < size; i++) v = v | (longint'(get_byte(a + i)) << (8 * i));
         if (!op.funct3[2] && size == 1 && v >= 128)   v = v - 256;
         if (!op.funct3[2] && size == 2 && v >= 32768) v = v - 65536;
         e.load_data = v[31:0];
      end else if (legal) begin
         r.be = 4'(((1 << size) - 1) << (a % 4));
         for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = op.store_data[8*(k % size) +: 8];
         for (int i = 0; i < size; i++) byte_mem[a + i] = op.store_data[8*i +: 8];
      end
   endtask

   function automatic exmem_t mk_op(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] sdata);
      exmem_t o;
      o            = '0;
      o.mem_read   = rd_en;
      o.mem_write  = wr_en;
      o.funct3     = f3;
      o.alu_result = addr;
      o.store_data = sdata;
      o.rd         = 5'($urandom_range(1, 31));
      o.reg_write  = 1'b1;
      o.result_src = 2'($urandom);
      o.pc_plus4   = $urandom;
      return o;
   endfunction

   function automatic exmem_t rand_op();
      int          k;
      logic [2:0]  f3;
      logic [31:0] addr;
      k    = $urandom_range(0, 9);
      f3   = 3'($urandom);
      addr = 32'h1000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
         case ($urandom_range(0, 4))
            0: f3 = F3_B;
            1: f3 = F3_H;
            2: f3 = F3_W;
            3: f3 = F3_BU;
            default: f3 = F3_HU;
         endcase
      end
      if (k <= 2) return mk_op(1'b0, 1'b0, f3, $urandom, $urandom);
      if (k <= 5) return mk_op(1'b1, 1'b0, f3, addr, $urandom);
      if (k <= 8) return mk_op(1'b0, 1'b1, f3, addr, $urandom);
      return mk_op(1'b1, 1'b1, f3, addr, $urandom);
   endfunction

   task automatic applyStimulus(input exmem_t op);
      bit     legal, is_load;
      memwb_t e;
      req_t   r;
      exp_t   x;
      int     stalls;
      model(op, legal, e, r, is_load);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      inputs   = op;
      if (legal) req_q.push_back(r);
      x.m        = e;
      x.chk_load = is_load;
      exp_q.push_back(x);
      stalls = 0;
      forever begin
         @(negedge clk);
         if (!stall) break;
         stalls++;
         if (stalls > 100) begin
            checkOutput("stall_bound", stalls, 0);
            break;
         end
      end
      checkOutput("stall_cycles", stalls, legal ? last_d1 + last_d2 + 2 : 0);
   endtask

   task automatic bubble();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inputs   = rand_op();
      @(negedge clk);
      checkOutput("bubble_stall", stall, 0);
   endtask

   // Monitor: every out_valid pops one expected MEM/WB bundle.
   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_out_valid", out_valid, 0);
            end else begin
               x = exp_q.pop_front();
               checkOutput("fault", fault, x.m.fault);
               checkOutput("out.fault", outputs.fault, x.m.fault);
               checkOutput("reg_write", outputs.reg_write, x.m.reg_write);
               checkOutput("rd", outputs.rd, x.m.rd);
               checkOutput("result", outputs.result, x.m.result);
               checkOutput("pc_plus4", outputs.pc_plus4, x.m.pc_plus4);
               checkOutput("result_src", outputs.result_src, x.m.result_src);
               if (x.chk_load) checkOutput("load_data", outputs.load_data, x.m.load_data);
            end
         end
      end
   end

   // Memory responder with random ready/rvalid latency and spurious handshakes.
   initial begin : responder
      req_t        r;
      int          d1, d2;
      logic [31:0] w;
      dmem_bus.dmem_ready  = 1'b0;
      dmem_bus.dmem_rvalid = 1'b0;
      dmem_bus.dmem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (manual) continue;
         dmem_bus.dmem_ready  = 1'b0;
         dmem_bus.dmem_rvalid = 1'b0;
         if (dmem_bus.dmem_req) begin
            if (req_q.size() == 0) begin
               checkOutput("unexpected_dmem_req", dmem_bus.dmem_req, 0);
               continue;
            end
            r  = req_q.pop_front();
            d1 = (force_d1 >= 0) ? force_d1 : $urandom_range(0, 3);
            d2 = (force_d2 >= 0) ? force_d2 : $urandom_range(0, 3);
            last_d1 = d1;
            last_d2 = d2;
            for (int i = 0; i <= d1; i++) begin
               if (i > 0) @(negedge clk);
               checkOutput("req_held", dmem_bus.dmem_req, 1);
               checkOutput("dmem_addr", dmem_bus.dmem_addr, r.addr);
               checkOutput("dmem_we", dmem_bus.dmem_we, r.we);
               checkOutput("dmem_be", dmem_bus.dmem_be, r.be);
               if (r.is_store) checkOutput("dmem_wdata", dmem_bus.dmem_wdata, r.wdata);
            end
            dmem_bus.dmem_ready = 1'b1;
            @(negedge clk);
            dmem_bus.dmem_ready = 1'b0;
            checkOutput("req_dropped_rsp", dmem_bus.dmem_req, 0);
            repeat (d2) @(negedge clk);
            for (int k = 0; k < 4; k++) w[8*k +: 8] = get_byte(r.addr + k);
            dmem_bus.dmem_rvalid = 1'b1;
            dmem_bus.dmem_rdata  = r.is_store ? $urandom : w;
         end else begin
            if ($urandom_range(0, 3) == 0) begin
               dmem_bus.dmem_rvalid = 1'b1;
               dmem_bus.dmem_rdata  = $urandom;
            end
            if ($urandom_range(0, 3) == 0) dmem_bus.dmem_ready = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      exmem_t op;
      bit     legal, is_load;
      memwb_t e;
      req_t   r;
      exp_t   x;
      int     cyc;

      $display("[TB] reset phase");
      in_valid = 1'b1;
      inputs   = mk_op(1'b1, 1'b0, F3_W, 32'h40, 32'h0);
      repeat (2) @(negedge clk);
      checkOutput("reset_stall", stall, 0);
      checkOutput("reset_req", dmem_bus.dmem_req, 0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_fault", fault, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      reset    = 1'b1;
      manual   = 1'b0;

      $display("[TB] directed cases");
      applyStimulus(mk_op(1'b0, 1'b0, 3'd0, 32'h1234, 32'h0));
      byte_mem[32'h1000] = 8'hFF;
      byte_mem[32'h1001] = 8'hFF;
      byte_mem[32'h1002] = 8'hFF;
      byte_mem[32'h1003] = 8'h80;
      force_d1 = 1;
      force_d2 = 1;
      applyStimulus(mk_op(1'b1, 1'b0, F3_B, 32'h1003, 32'h0));
      applyStimulus(mk_op(1'b1, 1'b0, F3_BU, 32'h1003, 32'h0));
      force_d1 = 3;
      force_d2 = 0;
      applyStimulus(mk_op(1'b0, 1'b1, F3_H, 32'h2002, 32'hABCD1234));
      force_d1 = 0;
      applyStimulus(mk_op(1'b1, 1'b0, F3_H, 32'h2002, 32'h0));
      force_d1 = -1;
      force_d2 = -1;
      applyStimulus(mk_op(1'b1, 1'b0, F3_W, 32'h3001, 32'h0));
      applyStimulus(mk_op(1'b0, 1'b1, F3_BU, 32'h3000, 32'h0));
      applyStimulus(mk_op(1'b1, 1'b1, F3_W, 32'h3000, 32'h0));

      $display("[TB] random cases");
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 7) == 0) bubble();
         applyStimulus(rand_op());
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("drain_exp_q", exp_q.size(), 0);
      checkOutput("drain_req_q", req_q.size(), 0);

      $display("[TB] reset during RSP");
      manual = 1'b1;
      @(posedge clk);
      #1;
      dmem_bus.dmem_ready  = 1'b0;
      dmem_bus.dmem_rvalid = 1'b0;
      in_valid = 1'b1;
      inputs   = mk_op(1'b1, 1'b0, F3_W, 32'h1040, 32'h0);
      @(negedge clk);
      checkOutput("rst_test_req", dmem_bus.dmem_req, 1);
      dmem_bus.dmem_ready = 1'b1;
      @(negedge clk);
      dmem_bus.dmem_ready = 1'b0;
      checkOutput("rst_test_rsp_stall", stall, 1);
      checkOutput("rst_test_rsp_req", dmem_bus.dmem_req, 0);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_stall", stall, 0);
      checkOutput("async_rst_out_valid", out_valid, 0);
      checkOutput("async_rst_fault", fault, 0);
      checkOutput("async_rst_req", dmem_bus.dmem_req, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      dmem_bus.dmem_rvalid = 1'b1;
      dmem_bus.dmem_rdata  = 32'hDEADBEEF;
      @(negedge clk);
      dmem_bus.dmem_rvalid = 1'b0;
      checkOutput("late_rvalid_out_valid", out_valid, 0);
      checkOutput("late_rvalid_stall", stall, 0);
      manual = 1'b0;
      applyStimulus(mk_op(1'b1, 1'b0, F3_HU, 32'h1042, 32'h0));

`ifdef DMEM_TIMEOUT_EN
      $display("[TB] response timeout");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      manual = 1'b1;
      dmem_bus.dmem_ready  = 1'b0;
      dmem_bus.dmem_rvalid = 1'b0;
      op = mk_op(1'b1, 1'b0, F3_W, 32'h1080, 32'h0);
      model(op, legal, e, r, is_load);
      e.fault     = 1'b1;
      e.reg_write = 1'b0;
      x.m         = e;
      x.chk_load  = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(x);
      in_valid = 1'b1;
      inputs   = op;
      @(negedge clk);
      dmem_bus.dmem_ready = 1'b1;
      cyc = 0;
      forever begin
         @(negedge clk);
         dmem_bus.dmem_ready = 1'b0;
         cyc++;
         if (!stall || cyc > 50) break;
      end
      checkOutput("timeout_cycle", cyc, 8);
      checkOutput("timeout_fault", fault, 1);
      checkOutput("timeout_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      dmem_bus.dmem_rvalid = 1'b1;
      @(negedge clk);
      dmem_bus.dmem_rvalid = 1'b0;
      checkOutput("timeout_late_rsp", out_valid, 0);
      manual = 1'b0;
`endif

      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("final_exp_q", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
